// File: rtl/uart_packet_rx_pkg.sv
// Shared definitions for the host-link UART packet receiver: packet size,
// bit-period derivation, host command codes and the bit-level FSM states.
package uart_packet_rx_pkg;

  localparam int unsigned PKT_BYTES_DEF = 16;

  localparam logic [7:0] CMD_LOAD_VECTOR = 8'h03;
  localparam logic [7:0] CMD_RUN_TEST    = 8'h05;
  localparam logic [7:0] CMD_READ_DATA   = 8'h06;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser on the line, then a mid-bit
// sampling FSM that emits one-clock byte_valid / frame_err pulses.
module uart_rx_byte
  import uart_packet_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned     HALF_BIT  = CLKS_PER_BIT / 2;
  localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic [1:0]       sync_q, sync_d;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d       = {sync_q[0], rx};
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    busy_d       = busy_q;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      // Half a bit in: a line back high means a glitch, not a start bit.
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = RX_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d   = RX_DATA;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d  = '0;
          busy_d = 1'b0;
          if (rx_s) begin
            state_d      = RX_IDLE;
            byte_valid_d = 1'b1;
          end else begin
            state_d     = RX_BREAK;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A low stop bit may be a line break; wait for idle before rearming.
      RX_BREAK: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: begin
        state_d = RX_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= 2'b11;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: rtl/uart_packet_rx.sv
// Host-link packet receiver: assembles PKT_BYTES UART bytes into one word and
// offers it on a valid/ready port. Define RX_TIMEOUT_EN to abort stale partial packets.
module uart_packet_rx
  import uart_packet_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned PKT_BYTES    = PKT_BYTES_DEF,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX,
  output logic [8*PKT_BYTES-1:0] PKT_DATA,
  output logic                   PKT_VALID,
  input  logic                   PKT_READY,
  output logic                   FRAME_ERR,
  output logic                   OVERRUN,
  output logic                   TIMEOUT,
  output logic                   BUSY
);

  localparam int unsigned      CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned      PKT_W        = 8 * PKT_BYTES;
  localparam int unsigned      IDX_W        = $clog2(PKT_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(PKT_BYTES - 1);

  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             frame_err;
  logic             busy;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PKT_W-1:0] asm_q, asm_d;
  logic [PKT_W-1:0] asm_fill;
  logic [PKT_W-1:0] pkt_data_q, pkt_data_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             overrun_q, overrun_d;
  logic             pkt_done;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned      TMO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned      TMO_W    = $clog2(TMO_CLKS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CLKS - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (CLK),
    .rst       (RST),
    .rx        (RX),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always_comb begin
    asm_d       = asm_q;
    idx_d       = idx_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = pkt_valid_q;
    overrun_d   = 1'b0;
    pkt_done    = 1'b0;
    asm_fill    = asm_q;
    for (int k = 0; k < PKT_BYTES; k++) begin
      if (idx_q == IDX_W'(k)) asm_fill[8*k +: 8] = rx_byte;
    end

    if (byte_valid) begin
      asm_d    = asm_fill;
      pkt_done = (idx_q == IDX_LAST);
      idx_d    = pkt_done ? '0 : idx_q + 1'b1;
    end
    if (frame_err) idx_d = '0;

    // A full output that is not being drained this cycle cannot take the new packet.
    if (pkt_done) begin
      if (pkt_valid_q && !PKT_READY) begin
        overrun_d = 1'b1;
      end else begin
        pkt_data_d  = asm_fill;
        pkt_valid_d = 1'b1;
      end
    end else if (pkt_valid_q && PKT_READY) begin
      pkt_valid_d = 1'b0;
    end

`ifdef RX_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = 1'b0;
    if (busy || (idx_q == '0)) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_LAST) begin
      tmo_cnt_d = '0;
      timeout_d = 1'b1;
      idx_d     = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q       <= '0;
      asm_q       <= '0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef RX_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      overrun_q   <= overrun_d;
`ifdef RX_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign PKT_DATA  = pkt_data_q;
  assign PKT_VALID = pkt_valid_q;
  assign OVERRUN   = overrun_q;
  assign FRAME_ERR = frame_err;
  assign BUSY      = busy;

`ifdef RX_TIMEOUT_EN
  assign TIMEOUT = timeout_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_BITS;
  assign TIMEOUT        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx, run at 16 clocks per bit to keep packets short.
module tb_uart_packet_rx;

  localparam int unsigned CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned BAUD        = 6_250_000;
  localparam int BIT_NOM  = 160;
  localparam int BIT_SLOW = 163;
  localparam int BIT_FAST = 157;

  localparam logic [127:0] P1   = 128'h0F0E0D0C_0B0A0908_07060504_03020103;
  localparam logic [127:0] P_FS = 128'h06FF0080_017FFE55_AAC33C12_34567805;
  localparam logic [127:0] P_FE = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E06;
  localparam logic [127:0] P3   = 128'h00112233_44556677_8899AABB_CCDDEE03;
  localparam logic [127:0] P4   = 128'hFFEEDDCC_BBAA9988_77665544_33221105;
  localparam logic [127:0] P5   = 128'h00000000_00000000_00171615_14131203;
  localparam logic [127:0] PA5  = {16{8'hA5}};
`ifdef RX_TIMEOUT_EN
  localparam logic [127:0] P_TMO = PA5;
  localparam int           TMO_PULSES = 1;
`else
  localparam logic [127:0] P_TMO = 128'hA5A5A5A5_A5A5A5A5_A5171615_14131203;
  localparam int           TMO_PULSES = 0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         RX = 1'b1;
  logic         PKT_READY = 1'b0;
  logic [127:0] PKT_DATA;
  logic         PKT_VALID;
  logic         FRAME_ERR;
  logic         OVERRUN;
  logic         TIMEOUT;
  logic         BUSY;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int to_cnt = 0;

  uart_packet_rx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .PKT_BYTES   (16),
    .TIMEOUT_BITS(20)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX       (RX),
    .PKT_DATA (PKT_DATA),
    .PKT_VALID(PKT_VALID),
    .PKT_READY(PKT_READY),
    .FRAME_ERR(FRAME_ERR),
    .OVERRUN  (OVERRUN),
    .TIMEOUT  (TIMEOUT),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (FRAME_ERR) fe_cnt++;
    if (OVERRUN) ov_cnt++;
    if (TIMEOUT) to_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int per);
    RX = 1'b0;
    #(per);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      #(per);
    end
    RX = stop_bit;
    #(per);
    RX = 1'b1;
  endtask

  task automatic send_pkt(input logic [127:0] p, input int n, input int per);
    for (int i = 0; i < n; i++) send_byte(p[8*i +: 8], 1'b1, per);
  endtask

  task automatic settle();
    repeat (40) @(negedge CLK);
  endtask

  task automatic handshake();
    @(negedge CLK);
    PKT_READY = 1'b1;
    @(negedge CLK);
    PKT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      RX = ~RX;
    end
    @(negedge CLK);
    checks++;
    if (PKT_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", PKT_VALID); end
    checks++;
    if (PKT_DATA !== 128'h0) begin errors++; $display("FAIL rst_data got %h exp 0", PKT_DATA); end
    checks++;
    if ({BUSY, FRAME_ERR, OVERRUN, TIMEOUT} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags got %b exp 0000", {BUSY, FRAME_ERR, OVERRUN, TIMEOUT});
    end
    RX = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b exp 0", BUSY); end
    checks++;
    if (PKT_VALID !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b exp 0", PKT_VALID); end
  endtask

  task automatic test_packet(input int per);
    int fe0;
    fe0 = fe_cnt;
    send_pkt(P1, 16, per);
    settle();
    checks++;
    if (PKT_VALID !== 1'b1) begin errors++; $display("FAIL pkt_valid_%0d got %b exp 1", per, PKT_VALID); end
    checks++;
    if (PKT_DATA[7:0] !== 8'h03) begin errors++; $display("FAIL pkt_hdr_%0d got %h exp 03", per, PKT_DATA[7:0]); end
    checks++;
    if (PKT_DATA[127:120] !== 8'h0F) begin errors++; $display("FAIL pkt_last_%0d got %h exp 0f", per, PKT_DATA[127:120]); end
    checks++;
    if (PKT_DATA !== P1) begin errors++; $display("FAIL pkt_data_%0d got %h exp %h", per, PKT_DATA, P1); end
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL pkt_no_fe_%0d got %0d exp 0", per, fe_cnt - fe0); end
    handshake();
    checks++;
    if (PKT_VALID !== 1'b0) begin errors++; $display("FAIL pkt_consume_%0d got %b exp 0", per, PKT_VALID); end
    checks++;
    if (PKT_DATA !== P1) begin errors++; $display("FAIL pkt_hold_%0d got %h exp %h", per, PKT_DATA, P1); end
  endtask

  task automatic test_false_start();
    int fe0;
    fe0 = fe_cnt;
    @(negedge CLK);
    RX = 1'b0;
    repeat (5) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL fs_busy_rise got %b exp 1", BUSY); end
    RX = 1'b1;
    repeat (2 * 16) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL fs_busy_fall got %b exp 0", BUSY); end
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL fs_no_fe got %0d exp 0", fe_cnt - fe0); end
    checks++;
    if (PKT_VALID !== 1'b0) begin errors++; $display("FAIL fs_valid got %b exp 0", PKT_VALID); end
    send_pkt(P_FS, 16, BIT_NOM);
    settle();
    checks++;
    if (PKT_DATA !== P_FS || PKT_VALID !== 1'b1) begin
      errors++; $display("FAIL fs_next_pkt got %h/%b exp %h/1", PKT_DATA, PKT_VALID, P_FS);
    end
    handshake();
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send_pkt(P4, 5, BIT_NOM);
    send_byte(8'h3C, 1'b0, BIT_NOM);
    #(BIT_NOM);
    @(negedge CLK);
    checks++;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL fe_pulse got %0d exp 1", fe_cnt - fe0); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL fe_busy got %b exp 0", BUSY); end
    send_pkt(P_FE, 16, BIT_NOM);
    settle();
    checks++;
    if (PKT_VALID !== 1'b1) begin errors++; $display("FAIL fe_next_valid got %b exp 1", PKT_VALID); end
    checks++;
    if (PKT_DATA !== P_FE) begin errors++; $display("FAIL fe_next_data got %h exp %h", PKT_DATA, P_FE); end
    checks++;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL fe_single got %0d exp 1", fe_cnt - fe0); end
    handshake();
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    send_pkt(P3, 16, BIT_NOM);
    settle();
    checks++;
    if (PKT_VALID !== 1'b1 || PKT_DATA !== P3) begin
      errors++; $display("FAIL ov_first got %h/%b exp %h/1", PKT_DATA, PKT_VALID, P3);
    end
    checks++;
    if (ov_cnt != ov0) begin errors++; $display("FAIL ov_none_yet got %0d exp 0", ov_cnt - ov0); end
    send_pkt(P4, 16, BIT_NOM);
    settle();
    checks++;
    if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL ov_pulse got %0d exp 1", ov_cnt - ov0); end
    checks++;
    if (PKT_DATA !== P3) begin errors++; $display("FAIL ov_keep_old got %h exp %h", PKT_DATA, P3); end
    checks++;
    if (PKT_VALID !== 1'b1) begin errors++; $display("FAIL ov_valid_held got %b exp 1", PKT_VALID); end
    handshake();
    checks++;
    if (PKT_VALID !== 1'b0) begin errors++; $display("FAIL ov_consume got %b exp 0", PKT_VALID); end
    checks++;
    if (PKT_DATA !== P3) begin errors++; $display("FAIL ov_data_kept got %h exp %h", PKT_DATA, P3); end
  endtask

  task automatic test_timeout();
    int to0;
    to0 = to_cnt;
    send_pkt(P5, 7, BIT_NOM);
    #(30 * BIT_NOM);
    send_pkt(PA5, 16, BIT_NOM);
    settle();
    checks++;
    if (to_cnt - to0 != TMO_PULSES) begin
      errors++; $display("FAIL tmo_pulses got %0d exp %0d", to_cnt - to0, TMO_PULSES);
    end
    checks++;
    if (PKT_VALID !== 1'b1) begin errors++; $display("FAIL tmo_valid got %b exp 1", PKT_VALID); end
    checks++;
    if (PKT_DATA !== P_TMO) begin errors++; $display("FAIL tmo_data got %h exp %h", PKT_DATA, P_TMO); end
  endtask

  initial begin
    test_reset();
    test_packet(BIT_SLOW);
    test_packet(BIT_FAST);
    test_false_start();
    test_frame_err();
    test_overrun();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
